uart_tx_fsm: RTL
================

Name: uart_tx_fsm

Overview:
Frame-sequencing controller for the UART transmitter. It drives the serializer's shift enable and the output-mux select, and tracks start, data, optional parity and stop-bit phases. It also produces the busy and done status used by the host and by the serializer's load gate. One bit period is one clk cycle; any baud scaling happens upstream of clk.

Parameters:
DATA_WIDTH, 8, data bits per frame; sets the watchdog limit for the DATA phase.
CNTR_WIDTH, 4, width of the internal data-phase watchdog counter; must satisfy 2^CNTR_WIDTH > DATA_WIDTH.

Ports:
clk  input  1  bit-rate clock; all state changes on rising edge
rst  input  1  asynchronous active-low reset
data_valid  input  1  host has a byte; accepted only in IDLE
par_en  input  1  1 = insert parity bit; sampled at frame accept
stop2  input  1  1 = two stop bits, 0 = one; sampled at frame accept
ser_done  input  1  serializer last-bit indication (high during final data-bit cycle)
ser_en  output  1  serializer shift enable
mux_sel  output  2  line select: 00 start(0), 01 idle/stop(1), 10 serial data, 11 parity
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse in final stop-bit cycle
frame_err  output  1  sticky; data phase overran without ser_done

Behaviour:
- Reset is async, active-low (rst=0). Forces state=IDLE, ser_en=0, mux_sel=01, busy=0, tx_done=0, frame_err=0, and clears the latched par_en/stop2 and all counters. Reset mid-frame aborts immediately; the line returns to idle (mux_sel=01).
- Outputs are Moore and decoded from registered state only:
  - IDLE: mux_sel=01, busy=0, ser_en=0.
  - START: mux_sel=00, busy=1, ser_en=0.
  - DATA: mux_sel=10, busy=1, ser_en=1.
  - PARITY: mux_sel=11, busy=1, ser_en=0.
  - STOP: mux_sel=01, busy=1, ser_en=0.
- IDLE->START when data_valid=1. The same edge latches par_en and stop2 into par_q and stop2_q. These stay constant for the whole frame; later changes to the inputs are ignored.
- START->DATA unconditionally after 1 cycle. The data watchdog counter is cleared.
- DATA: each cycle increments the watchdog.
  - If ser_done=1: next state is PARITY if par_q=1, else STOP.
  - If ser_done=0 and the watchdog has reached DATA_WIDTH-1: set frame_err=1 and go to STOP. frame_err stays set until reset.
  - In a nominal frame DATA lasts exactly DATA_WIDTH cycles.
- PARITY->STOP after 1 cycle.
- STOP lasts 1 cycle, or 2 cycles if stop2_q=1, using a 1-bit stop counter. tx_done=1 in the final stop cycle only. The next state is always IDLE.
- No back-to-back frames: IDLE occupies at least 1 cycle between frames. data_valid asserted while busy=1 is ignored and does not queue.
- Frame length start-to-last-stop = 1 + DATA_WIDTH + par_q + (1 + stop2_q) cycles. The earliest next START is this length + 1 cycle after the previous START.
- ser_done outside DATA is ignored.
- Unreachable state encodings recover to IDLE on the next edge.

Test Plan:
- Reset, then data_valid pulse with par_en=0, stop2=0 -> mux_sel 01,00,10x8,01,01. busy high for 10 cycles. ser_en high for exactly 8. tx_done on cycle 10 after accept.
- par_en=1, stop2=1 -> mux_sel sequence 00,10x8,11,01,01. busy high for 12 cycles. tx_done only on the second stop cycle.
- Toggle par_en and stop2 and pulse data_valid mid-frame -> frame timing matches the values latched at accept. No second frame starts until IDLE.
- data_valid held high continuously -> frames repeat with exactly 1 IDLE cycle (busy=0) between consecutive STOP and START.
- Hold ser_done=0 through DATA -> after 8 DATA cycles frame_err=1, then STOP and IDLE. frame_err stays 1 across later good frames until rst.
- Assert rst=0 in the DATA phase at cycle 4 -> outputs go to reset values asynchronously. Release -> IDLE, and the next data_valid starts a clean frame.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: Moore outputs decoded from registered state, one bit per clk.
// No backpressure; data_valid is accepted only in IDLE and is otherwise dropped, never queued.
module uart_tx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int CNTR_WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid,
  input  logic       par_en,
  input  logic       stop2,
  input  logic       ser_done,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       busy,
  output logic       tx_done,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] WDOG_LAST = CNTR_WIDTH'(DATA_WIDTH - 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_IDLE   = 2'b01;
  localparam logic [1:0] MUX_DATA   = 2'b10;
  localparam logic [1:0] MUX_PARITY = 2'b11;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_par_q;
  logic                  r_stop2_q;
  logic                  r_stop_cnt;
  logic                  r_frame_err;
  logic [CNTR_WIDTH-1:0] r_wdog;

  logic w_accept;
  logic w_wdog_expired;
  logic w_overrun;
  logic w_stop_last;

  assign w_accept       = (r_state == S_IDLE) && data_valid;
  assign w_wdog_expired = (r_wdog == WDOG_LAST);
  assign w_overrun      = (r_state == S_DATA) && !ser_done && w_wdog_expired;
  // With two stop bits the first STOP cycle has r_stop_cnt=0, the second has 1.
  assign w_stop_last    = !r_stop2_q || r_stop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = data_valid ? S_START : S_IDLE;
      S_START:  w_state_nxt = S_DATA;
      S_DATA: begin
        if (ser_done) begin
          w_state_nxt = r_par_q ? S_PARITY : S_STOP;
        end else if (w_wdog_expired) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: w_state_nxt = S_STOP;
      S_STOP:   w_state_nxt = w_stop_last ? S_IDLE : S_STOP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ser_en  = 1'b0;
    mux_sel = MUX_IDLE;
    busy    = 1'b0;
    tx_done = 1'b0;
    case (r_state)
      S_START: begin
        mux_sel = MUX_START;
        busy    = 1'b1;
      end
      S_DATA: begin
        mux_sel = MUX_DATA;
        busy    = 1'b1;
        ser_en  = 1'b1;
      end
      S_PARITY: begin
        mux_sel = MUX_PARITY;
        busy    = 1'b1;
      end
      S_STOP: begin
        mux_sel = MUX_IDLE;
        busy    = 1'b1;
        tx_done = w_stop_last;
      end
      default: begin
        mux_sel = MUX_IDLE;
      end
    endcase
  end

  // Frame options are frozen at accept so mid-frame input changes cannot alter timing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_q   <= 1'b0;
      r_stop2_q <= 1'b0;
    end else if (w_accept) begin
      r_par_q   <= par_en;
      r_stop2_q <= stop2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog <= '0;
    end else if (r_state == S_START) begin
      r_wdog <= '0;
    end else if (r_state == S_DATA) begin
      r_wdog <= r_wdog + CNTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stop_cnt <= 1'b0;
    end else if (r_state == S_STOP) begin
      r_stop_cnt <= r_stop2_q && !r_stop_cnt;
    end else begin
      r_stop_cnt <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
    end else if (w_overrun) begin
      r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;

endmodule
